vram_fill_engine: RTL and testbench

- Parametrised, command-driven successor to the fixed reset-time VRAM filler.
- Accepts queued fill commands (base, length, mode, seed) and streams writes onto the GPU VRAM write port (data/address/write_enable).
- Stalls while the bus is not granted.
- busy drives the GPU reset/hold the same way the old fill-in-progress flag did, so benches and the boot ROM path can preload pattern memory and the object table without hand-written write sequences.

---
 rtl/vram_fill_engine.sv | 165 ++++++++++++++++
 tb/tb_vram_fill_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_engine.sv
// Command-driven VRAM fill engine: queued fill commands streamed onto the GPU VRAM write port.
// Optional macro VRAM_FILL_CHECKSUM_EN adds a running XOR checksum of the written data.
module vram_fill_engine #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                  clk_12_5875,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [1:0]            cmd_mode,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic                  grant,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] vram_data,
    output logic [ADDR_WIDTH-1:0] vram_address,
    output logic                  vram_write_enable,
    output logic                  busy,
`ifdef VRAM_FILL_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  done
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [PW:0] FULL = (PW+1)'(CMD_DEPTH);
    localparam logic [1:0] MODE_INCR = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] fifo_base [CMD_DEPTH];
    logic [ADDR_WIDTH:0]   fifo_len  [CMD_DEPTH];
    logic [1:0]            fifo_mode [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_seed [CMD_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count, count_next;
    logic                  push, pop;

    logic [ADDR_WIDTH-1:0] cur_base;
    logic [ADDR_WIDTH:0]   cur_len;
    logic [1:0]            cur_mode;
    logic [DATA_WIDTH-1:0] cur_seed;
    logic [ADDR_WIDTH:0]   idx;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  write_now;
    logic                  last_write;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign cmd_ready  = (count != FULL);
    assign push       = cmd_valid && cmd_ready && !abort;
    assign write_now  = (state == WRITE) && grant && !abort;
    assign last_write = (idx == cur_len - LW'(1));
    assign wr_addr    = cur_base + idx[ADDR_WIDTH-1:0];

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE:    if (count != '0) begin
                         pop        = 1'b1;
                         next_state = LOAD;
                     end
            LOAD:    next_state = (cur_len == '0) ? DONE : WRITE;
            WRITE:   if (grant && last_write) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
            pop        = 1'b0;
        end
    end

    always_comb begin
        count_next = count + (PW+1)'(push) - (PW+1)'(pop);
        if (abort) count_next = '0;
    end

    always_comb begin
        case (cur_mode)
            MODE_INCR: wr_data = cur_seed + DATA_WIDTH'(idx);
            MODE_XOR:  wr_data = cur_seed ^ DATA_WIDTH'(wr_addr);
            default:   wr_data = cur_seed;
        endcase
    end

    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= next_state;
            count <= count_next;
            busy  <= (count_next != '0) || (next_state != IDLE);
            done  <= (next_state == DONE);
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: command storage has no reset; count alone decides which entries are live.
    always_ff @(posedge clk_12_5875) begin
        if (push) begin
            fifo_base[wr_ptr] <= cmd_base;
            fifo_len[wr_ptr]  <= cmd_len;
            fifo_mode[wr_ptr] <= cmd_mode;
            fifo_seed[wr_ptr] <= cmd_seed;
        end
    end

    // The popped entry is captured at once, since a push may reuse its slot during LOAD.
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            cur_base          <= '0;
            cur_len           <= '0;
            cur_mode          <= '0;
            cur_seed          <= '0;
            idx               <= '0;
            vram_write_enable <= 1'b0;
            vram_address      <= '0;
            vram_data         <= '0;
        end else begin
            if (pop) begin
                cur_base <= fifo_base[rd_ptr];
                cur_len  <= fifo_len[rd_ptr];
                cur_mode <= fifo_mode[rd_ptr];
                cur_seed <= fifo_seed[rd_ptr];
            end
            if (state == LOAD)  idx <= '0;
            else if (write_now) idx <= idx + LW'(1);
            vram_write_enable <= write_now;
            if (write_now) begin
                vram_address <= wr_addr;
                vram_data    <= wr_data;
            end
        end
    end

`ifdef VRAM_FILL_CHECKSUM_EN
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n)                      checksum <= '0;
        else if (abort || state == LOAD) checksum <= '0;
        else if (write_now)              checksum <= checksum ^ wr_data;
    end
`endif

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench for vram_fill_engine: directed scenarios plus randomized commands
// compared against a per-command write-list model and an in-order done scoreboard.
module tb_vram_fill_engine;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_len = '0;
    logic [1:0]    cmd_mode = '0;
    logic [DW-1:0] cmd_seed = '0;
    logic          grant = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] vram_data;
    logic [AW-1:0] vram_address;
    logic          vram_write_enable;
    logic          busy;
    logic          done;
`ifdef VRAM_FILL_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    vram_fill_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(4)) dut (
        .clk_12_5875      (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_base         (cmd_base),
        .cmd_len          (cmd_len),
        .cmd_mode         (cmd_mode),
        .cmd_seed         (cmd_seed),
        .grant            (grant),
        .abort            (abort),
        .vram_data        (vram_data),
        .vram_address     (vram_address),
        .vram_write_enable(vram_write_enable),
        .busy             (busy),
`ifdef VRAM_FILL_CHECKSUM_EN
        .checksum         (checksum),
`endif
        .done             (done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            id;
    } wr_t;

    wr_t           exp_q[$];
    int            exp_done[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            writes_seen = 0;
    int            dones_seen = 0;
    int            next_id = 0;
    bit            rand_grant = 1'b0;
    logic [DW-1:0] last_csum = '0;
    wr_t           mon_w;
    int            mon_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the full list of (address, data) writes a command must produce.
    task automatic model_cmd(input int base, input int len, input int mode, input int seed);
        wr_t           w;
        int            a;
        logic [DW-1:0] csum;
        csum = '0;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % (1 << AW);
            case (mode)
                1:       w.data = DW'((seed + i) % (1 << DW));
                2:       w.data = DW'(seed ^ (a % (1 << DW)));
                default: w.data = DW'(seed);
            endcase
            w.addr = AW'(a);
            w.id   = next_id;
            exp_q.push_back(w);
            csum ^= w.data;
        end
        exp_done.push_back(next_id);
        next_id++;
        last_csum = csum;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_grant) grant = 1'($urandom_range(0, 1));
    endtask

    task automatic push_cmd(input int base, input int len, input int mode, input int seed);
        bit acc;
        acc       = 1'b0;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        cmd_mode  = 2'(mode);
        cmd_seed  = DW'(seed);
        cmd_valid = 1'b1;
        for (int t = 0; t < 2000 && !acc; t++) begin
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("push_accepted", 32'(acc), 32'd1);
        if (acc) model_cmd(base, len, mode, seed);
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0 || exp_done.size() != 0) && t < budget) begin
            tick();
            t++;
        end
        check("idle_within_budget", 32'(t < budget), 32'd1);
    endtask

    task automatic check_csum(input string tag, input logic [DW-1:0] exp);
`ifdef VRAM_FILL_CHECKSUM_EN
        check(tag, 32'(checksum), 32'(exp));
`endif
    endtask

    // Scoreboard: every strobe must match the next modelled write, every done the next command.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vram_write_enable) begin
                writes_seen++;
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_w = exp_q.pop_front();
                    check("wr_addr", 32'(vram_address), 32'(mon_w.addr));
                    check("wr_data", 32'(vram_data), 32'(mon_w.data));
                end
            end
            if (done) begin
                dones_seen++;
                check("done_expected", 32'(exp_done.size() != 0), 32'd1);
                if (exp_done.size() != 0) begin
                    mon_id = exp_done.pop_front();
                    if (exp_q.size() != 0) check("done_after_all_writes", 32'(exp_q[0].id > mon_id), 32'd1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0, w0, n, pg;
        // Reset state
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_we", 32'(vram_write_enable), 32'd0);
        check("rst_addr", 32'(vram_address), 32'd0);
        check("rst_data", 32'(vram_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_csum("rst_checksum", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        grant = 1'b1;
        tick();

        // CONST fill: first strobe 3 edges after the push edge, 8 in a row, done with the last
        d0 = dones_seen; w0 = writes_seen;
        push_cmd('h000, 8, 0, 'h0F);
        check("t1_busy_after_push", 32'(busy), 32'd1);
        check("t1_no_early_write0", 32'(vram_write_enable), 32'd0);
        tick();
        check("t1_no_early_write1", 32'(vram_write_enable), 32'd0);
        tick();
        check("t1_no_early_write2", 32'(vram_write_enable), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t1_strobe", 32'(vram_write_enable), 32'd1);
        end
        check("t1_done_pulse", 32'(done), 32'd1);
        tick();
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_done_count", 32'(dones_seen - d0), 32'd1);
        check("t1_write_count", 32'(writes_seen - w0), 32'd8);
        check_csum("t1_checksum", last_csum);

        // INCR wrapping through the data width
        push_cmd('h800, 4, 1, 'hFE);
        wait_idle(100);
        check_csum("t2_checksum", last_csum);

        // XOR across the address wrap with grant toggling
        w0 = writes_seen;
        push_cmd('hFFE, 4, 2, 'hA5);
        for (int t = 0; t < 60 && (busy || exp_q.size() != 0); t++) begin
            pg = int'(grant);
            tick();
            if (pg == 0) check("t3_no_strobe_without_grant", 32'(vram_write_enable), 32'd0);
            grant = ~grant;
        end
        grant = 1'b1;
        wait_idle(50);
        check("t3_write_count", 32'(writes_seen - w0), 32'd4);
        check_csum("t3_checksum", last_csum);

        // Backpressure: engine stalled on a long command, FIFO fills after 4 more pushes
        grant = 1'b0;
        d0 = dones_seen;
        push_cmd($urandom_range(0, 4095), 16, $urandom_range(0, 3), $urandom_range(0, 255));
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++)
            push_cmd($urandom_range(0, 4095), $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 255));
        check("t4_ready_low_when_full", 32'(cmd_ready), 32'd0);
        tick();
        check("t4_ready_stays_low", 32'(cmd_ready), 32'd0);
        check("t4_busy_while_stalled", 32'(busy), 32'd1);
        grant = 1'b1;
        push_cmd($urandom_range(0, 4095), $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 255));
        wait_idle(400);
        check("t4_done_count", 32'(dones_seen - d0), 32'd6);
        check_csum("t4_checksum", last_csum);

        // Zero-length command followed by a short CONST fill
        d0 = dones_seen; w0 = writes_seen;
        push_cmd($urandom_range(0, 4095), 0, $urandom_range(0, 3), $urandom_range(0, 255));
        push_cmd('h010, 2, 0, 'h33);
        wait_idle(100);
        check("t5_done_count", 32'(dones_seen - d0), 32'd2);
        check("t5_write_count", 32'(writes_seen - w0), 32'd2);

        // Abort after 3 of 16 writes with one command queued; a push offered alongside is dropped
        push_cmd($urandom_range(0, 4095), 16, $urandom_range(0, 3), $urandom_range(0, 255));
        push_cmd($urandom_range(0, 4095), 5, $urandom_range(0, 3), $urandom_range(0, 255));
        n = 0;
        for (int t = 0; t < 30 && n < 3; t++) begin
            tick();
            if (vram_write_enable) n++;
        end
        check("t6_three_writes_seen", 32'(n), 32'd3);
        d0 = dones_seen;
        abort = 1'b1;
        cmd_base = '0; cmd_len = 13'd4; cmd_mode = '0; cmd_seed = 8'h77;
        cmd_valid = 1'b1;
        tick();
        abort = 1'b0;
        cmd_valid = 1'b0;
        exp_q.delete();
        exp_done.delete();
        check("t6_abort_strobe", 32'(vram_write_enable), 32'd0);
        check("t6_abort_busy", 32'(busy), 32'd0);
        check("t6_abort_ready", 32'(cmd_ready), 32'd1);
        check("t6_abort_done", 32'(done), 32'd0);
        check_csum("t6_abort_checksum", 8'h00);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t6_quiet_after_abort", 32'({busy, vram_write_enable, done}), 32'd0);
        end
        check("t6_no_done", 32'(dones_seen - d0), 32'd0);

        // Asynchronous reset in the middle of a fill
        push_cmd($urandom_range(0, 4095), 16, $urandom_range(0, 3), $urandom_range(0, 255));
        for (int k = 0; k < 6; k++) tick();
        d0 = dones_seen;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_done.delete();
        check("t7_rst_we", 32'(vram_write_enable), 32'd0);
        check("t7_rst_addr", 32'(vram_address), 32'd0);
        check("t7_rst_data", 32'(vram_data), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_done", 32'(done), 32'd0);
        check("t7_rst_ready", 32'(cmd_ready), 32'd1);
        check_csum("t7_rst_checksum", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("t7_no_done_after_reset", 32'(dones_seen - d0), 32'd0);
        check("t7_idle_after_reset", 32'(busy), 32'd0);

        // Full-length fill touches every address once
        w0 = writes_seen;
        push_cmd($urandom_range(0, 4095), 4096, $urandom_range(0, 3), $urandom_range(0, 255));
        wait_idle(4200);
        check("t8_full_length_writes", 32'(writes_seen - w0), 32'd4096);
        check_csum("t8_checksum", last_csum);

        // Randomized commands under random grant
        rand_grant = 1'b1;
        d0 = dones_seen;
        for (int k = 0; k < 12; k++)
            push_cmd($urandom_range(0, 4095), $urandom_range(0, 40), $urandom_range(0, 3), $urandom_range(0, 255));
        wait_idle(3000);
        rand_grant = 1'b0;
        grant = 1'b1;
        check("t9_done_count", 32'(dones_seen - d0), 32'd12);
        check_csum("t9_checksum", last_csum);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
